// File: rtl/icache_refill_responder.sv
// icache_refill_responder: memory-side responder for instruction-cache line refills.
// Takes one line request at a time, waits LATENCY cycles, reads the line one
// 64-bit beat per cycle and returns it with its line address and error status.
// Backing memory is reached through a same-cycle read port: mem_rd_en is high
// for exactly one cycle per beat, and mem_rd_data must be valid in that same
// cycle. This is the hardware form of one blocking dpi_mem_read(addr, 8) call.
module icache_refill_responder #(
    parameter int unsigned       ADDR_W     = 64,
    parameter int unsigned       LINE_BYTES = 16,
    parameter int unsigned       BEAT_BYTES = 8,
    parameter int unsigned       LATENCY    = 4,
    parameter logic [ADDR_W-1:0] MEM_BASE   = 64'h0000_0000_8000_0000,
    parameter logic [ADDR_W-1:0] MEM_SIZE   = 64'h0000_0000_0800_0000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [ADDR_W-1:0]       req_addr,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [LINE_BYTES*8-1:0] resp_data,
    output logic [ADDR_W-1:0]       resp_addr,
    output logic                    resp_err,
    output logic                    mem_rd_en,
    output logic [ADDR_W-1:0]       mem_rd_addr,
    input  logic [63:0]             mem_rd_data
);

    localparam int unsigned BEATS  = LINE_BYTES / BEAT_BYTES;
    localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned CNT_W  = $clog2(LATENCY + 2);

    localparam logic [ADDR_W-1:0] OFF_MASK  = ADDR_W'(LINE_BYTES - 1);
    // Window bounds carry one extra bit so that MEM_BASE+MEM_SIZE never wraps.
    localparam logic [ADDR_W:0]   WIN_LO    = {1'b0, MEM_BASE};
    localparam logic [ADDR_W:0]   WIN_HI    = {1'b0, MEM_BASE} + {1'b0, MEM_SIZE};
    localparam logic [CNT_W-1:0]  LAT_LOAD  = CNT_W'(LATENCY);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_BEAT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t                    r_state;
    logic [CNT_W-1:0]          r_cnt;
    logic [BEAT_W-1:0]         r_beat_idx;
    logic [ADDR_W-1:0]         r_line_addr;
    logic                      r_err;
    logic [LINE_BYTES*8-1:0]   r_line;
    logic                      r_resp_valid;
    logic [LINE_BYTES*8-1:0]   r_resp_data;
    logic [ADDR_W-1:0]         r_resp_addr;
    logic                      r_resp_err;

    logic [ADDR_W-1:0]         w_line_addr_in;
    logic                      w_err_in;
    logic [LINE_BYTES*8-1:0]   w_line_merged;

    // Request decode: line-align the address and classify it against the window.
    always_comb begin
        w_line_addr_in = req_addr & ~OFF_MASK;
        w_err_in       = ({1'b0, w_line_addr_in} < WIN_LO) ||
                         ({1'b0, w_line_addr_in} >= WIN_HI);
    end

    // Line buffer with the current beat's read data merged into its slot.
    always_comb begin
        w_line_merged = r_line;
        w_line_merged[{r_beat_idx, 6'd0} +: 64] = mem_rd_data;
    end

    // Memory read port and request-side ready, decoded from the state register only.
    always_comb begin
        req_ready   = (r_state == S_IDLE);
        mem_rd_en   = (r_state == S_BEAT);
        mem_rd_addr = r_line_addr + (ADDR_W'(r_beat_idx) << 3'd3);
    end

    // Refill FSM: accept, wait, fetch beats, then hold the response until taken.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_beat_idx   <= '0;
            r_line_addr  <= '0;
            r_err        <= 1'b0;
            r_line       <= '0;
            r_resp_valid <= 1'b0;
            r_resp_data  <= '0;
            r_resp_addr  <= '0;
            r_resp_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_line_addr <= w_line_addr_in;
                        r_err       <= w_err_in;
                        r_cnt       <= LAT_LOAD;
                        r_beat_idx  <= '0;
                        if (LATENCY > 0) begin
                            r_state <= S_WAIT;
                        end else if (w_err_in) begin
                            // Out-of-window with no latency: respond without touching memory.
                            r_state      <= S_RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_data  <= '0;
                            r_resp_addr  <= w_line_addr_in;
                            r_resp_err   <= 1'b1;
                        end else begin
                            r_state <= S_BEAT;
                        end
                    end
                end
                S_WAIT: begin
                    if (r_cnt == CNT_W'(1)) begin
                        if (r_err) begin
                            r_state      <= S_RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_data  <= '0;
                            r_resp_addr  <= r_line_addr;
                            r_resp_err   <= 1'b1;
                        end else begin
                            r_state <= S_BEAT;
                        end
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                S_BEAT: begin
                    r_line <= w_line_merged;
                    if (r_beat_idx == LAST_BEAT) begin
                        r_state      <= S_RESP;
                        r_beat_idx   <= '0;
                        r_resp_valid <= 1'b1;
                        r_resp_data  <= w_line_merged;
                        r_resp_addr  <= r_line_addr;
                        r_resp_err   <= 1'b0;
                    end else begin
                        r_beat_idx <= r_beat_idx + BEAT_W'(1);
                    end
                end
                S_RESP: begin
                    // Data, address and error stay as they are after the handshake.
                    if (resp_ready) begin
                        r_state      <= S_IDLE;
                        r_resp_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_resp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign resp_valid = r_resp_valid;
    assign resp_data  = r_resp_data;
    assign resp_addr  = r_resp_addr;
    assign resp_err   = r_resp_err;

endmodule

// File: tb/tb_icache_refill_responder.sv
// Self-checking bench for icache_refill_responder: default instance (LATENCY=4)
// plus a LATENCY=0 instance, each backed by a behavioural memory in the bench.
module tb_icache_refill_responder;

    logic         clk;
    logic         rst;

    logic         req_valid, req_ready, resp_valid, resp_ready, resp_err;
    logic [63:0]  req_addr, resp_addr, mem_rd_addr, mem_rd_data;
    logic [127:0] resp_data;
    logic         mem_rd_en;

    logic         req_valid0, req_ready0, resp_valid0, resp_ready0, resp_err0;
    logic [63:0]  req_addr0, resp_addr0, mem_rd_addr0, mem_rd_data0;
    logic [127:0] resp_data0;
    logic         mem_rd_en0;

    int unsigned  n_checks = 0;
    int unsigned  n_errors = 0;
    int unsigned  rd_cnt   = 0;
    int unsigned  rd_cnt0  = 0;

    // Behavioural memory contents: a fixed function of the word address.
    function automatic logic [63:0] mem_word(input logic [63:0] a);
        return {a[31:0] ^ 32'hC3C3_3C3C, a[31:0] + 32'h0101_0101};
    endfunction

    function automatic logic [127:0] mem_line(input logic [63:0] a);
        return {mem_word(a + 64'd8), mem_word(a)};
    endfunction

    assign mem_rd_data  = mem_word(mem_rd_addr);
    assign mem_rd_data0 = mem_word(mem_rd_addr0);

    icache_refill_responder u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_addr(resp_addr), .resp_err(resp_err),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data)
    );

    icache_refill_responder #(.LATENCY(0)) u_dut0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid0), .req_ready(req_ready0), .req_addr(req_addr0),
        .resp_valid(resp_valid0), .resp_ready(resp_ready0), .resp_data(resp_data0),
        .resp_addr(resp_addr0), .resp_err(resp_err0),
        .mem_rd_en(mem_rd_en0), .mem_rd_addr(mem_rd_addr0), .mem_rd_data(mem_rd_data0)
    );

    // Clock: period 10, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count memory reads (one per cycle with the read strobe high).
    always @(posedge clk) begin
        if (mem_rd_en)  rd_cnt  <= rd_cnt + 1;
        if (mem_rd_en0) rd_cnt0 <= rd_cnt0 + 1;
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Present a request at posedge+1; returns at E0+1 with the valid dropped.
    task automatic issue(input int sel, input logic [63:0] a);
        chk("req_ready_before_req", (sel == 0) ? req_ready : req_ready0, 1'b1);
        if (sel == 0) begin req_valid = 1'b1; req_addr = a; end
        else begin req_valid0 = 1'b1; req_addr0 = a; end
        @(posedge clk); #1;
        req_valid  = 1'b0;
        req_valid0 = 1'b0;
    endtask

    // Count edges after E0 until resp_valid is seen (bounded).
    task automatic wait_resp(input int sel, output int cyc);
        cyc = 0;
        while (cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            if ((sel == 0 && resp_valid) || (sel == 1 && resp_valid0)) break;
        end
    endtask

    task automatic handshake(input int sel);
        if (sel == 0) resp_ready = 1'b1; else resp_ready0 = 1'b1;
        @(posedge clk); #1;
        resp_ready  = 1'b0;
        resp_ready0 = 1'b0;
        chk("resp_valid_after_hs", (sel == 0) ? resp_valid : resp_valid0, 1'b0);
        chk("req_ready_after_hs",  (sel == 0) ? req_ready  : req_ready0,  1'b1);
    endtask

    // Full request/response with checks on latency, address, data, error and reads.
    task automatic run_txn(input int sel, input logic [63:0] a, input logic [63:0] exp_line,
                           input logic exp_err, input int exp_lat);
        int          cyc;
        int unsigned rd0;
        logic [127:0] exp_data;
        rd0 = (sel == 0) ? rd_cnt : rd_cnt0;
        exp_data = exp_err ? 128'd0 : mem_line(exp_line);
        issue(sel, a);
        wait_resp(sel, cyc);
        chk("latency",   cyc, exp_lat);
        chk("resp_addr", (sel == 0) ? resp_addr : resp_addr0, exp_line);
        chk("resp_err",  (sel == 0) ? resp_err  : resp_err0,  exp_err);
        chk("resp_data", (sel == 0) ? resp_data : resp_data0, exp_data);
        chk("mem_reads", ((sel == 0) ? rd_cnt : rd_cnt0) - rd0, exp_err ? 0 : 2);
        handshake(sel);
    endtask

    typedef struct {
        logic [63:0] addr;
        logic [63:0] exp_line;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int          cyc;
        int          seen;
        int unsigned rd0;
        logic [127:0] hold_data;

        vecs[0] = '{64'h0000_0000_8000_0004, 64'h0000_0000_8000_0000, 1'b0, 6};
        vecs[1] = '{64'h0000_0000_0000_1000, 64'h0000_0000_0000_1000, 1'b1, 4};
        vecs[2] = '{64'h0000_0000_8800_0000, 64'h0000_0000_8800_0000, 1'b1, 4};
        vecs[3] = '{64'h0000_0000_87FF_FFF0, 64'h0000_0000_87FF_FFF0, 1'b0, 6};
        vecs[4] = '{64'h0000_0000_87FF_FFFF, 64'h0000_0000_87FF_FFF0, 1'b0, 6};
        vecs[5] = '{64'h0000_0000_7FFF_FFF8, 64'h0000_0000_7FFF_FFF0, 1'b1, 4};

        rst = 1'b0;
        req_valid = 1'b0;  req_addr = 64'd0;  resp_ready = 1'b0;
        req_valid0 = 1'b0; req_addr0 = 64'd0; resp_ready0 = 1'b0;

        // Reset state
        #22;
        chk("rst_req_ready",  req_ready,  1'b1);
        chk("rst_resp_valid", resp_valid, 1'b0);
        chk("rst_resp_data",  resp_data,  128'd0);
        chk("rst_resp_addr",  resp_addr,  64'd0);
        chk("rst_resp_err",   resp_err,   1'b0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Table-driven transactions on the default instance
        for (int i = 0; i < 6; i++) begin
            run_txn(0, vecs[i].addr, vecs[i].exp_line, vecs[i].exp_err, vecs[i].exp_lat);
        end

        // Zero-latency instance
        run_txn(1, 64'h0000_0000_8000_001C, 64'h0000_0000_8000_0010, 1'b0, 2);
        run_txn(1, 64'h0000_0000_8000_0028, 64'h0000_0000_8000_0020, 1'b0, 2);

        // Back-pressure: response held while a new request waits
        issue(0, 64'h0000_0000_8000_0040);
        wait_resp(0, cyc);
        chk("bp_latency", cyc, 6);
        hold_data = mem_line(64'h0000_0000_8000_0040);
        req_valid = 1'b1;
        req_addr  = 64'h0000_0000_8000_0088;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            chk("bp_resp_valid", resp_valid, 1'b1);
            chk("bp_resp_addr",  resp_addr,  64'h0000_0000_8000_0040);
            chk("bp_resp_data",  resp_data,  hold_data);
            chk("bp_resp_err",   resp_err,   1'b0);
            chk("bp_req_ready",  req_ready,  1'b0);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        chk("bp_hs_valid",     resp_valid, 1'b0);
        chk("bp_hs_req_ready", req_ready,  1'b1);
        chk("bp_hs_addr_kept", resp_addr,  64'h0000_0000_8000_0040);
        chk("bp_hs_data_kept", resp_data,  hold_data);
        @(posedge clk); #1;
        chk("bp_second_accepted", req_ready, 1'b0);
        req_valid = 1'b0;
        wait_resp(0, cyc);
        chk("bp2_latency", cyc, 6);
        chk("bp2_addr", resp_addr, 64'h0000_0000_8000_0080);
        chk("bp2_data", resp_data, mem_line(64'h0000_0000_8000_0080));
        handshake(0);

        // Asynchronous reset while waiting
        rd0 = rd_cnt;
        issue(0, 64'h0000_0000_8000_0100);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("rstw_resp_valid", resp_valid, 1'b0);
        chk("rstw_req_ready",  req_ready,  1'b1);
        chk("rstw_resp_addr",  resp_addr,  64'd0);
        #2;
        rst = 1'b1;
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (resp_valid) seen++;
        end
        chk("rstw_no_resp", seen, 0);
        chk("rstw_no_reads", rd_cnt - rd0, 0);

        // Asynchronous reset mid-beat (after the first beat was read)
        rd0 = rd_cnt;
        issue(0, 64'h0000_0000_8000_0200);
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("rstb_resp_valid", resp_valid, 1'b0);
        chk("rstb_req_ready",  req_ready,  1'b1);
        chk("rstb_one_read",   rd_cnt - rd0, 1);
        #2;
        rst = 1'b1;
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (resp_valid) seen++;
        end
        chk("rstb_no_resp", seen, 0);
        chk("rstb_reads_stopped", rd_cnt - rd0, 1);

        // Normal operation after the aborts
        run_txn(0, 64'h0000_0000_8000_0308, 64'h0000_0000_8000_0300, 1'b0, 6);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
